mem2_stage: RTL

MEM2_STAGE -- requirements
Module: mem2_stage

---
 rtl/mem_pkg.sv | 12 +
 rtl/store_buffer.sv | 45 ++++
 rtl/mem2_stage.sv | 60 ++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared sizes and store-buffer entry type for the Mem2 stage
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int MEM_DEPTH = 256;
  localparam int IDX_W = 8;
  localparam int SB_DEPTH = 2;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } sbEntry_t;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: two-entry store FIFO with youngest-match load forwarding and drain control
module store_buffer
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic load,
  input  logic [IDX_W-1:0] pushIdx,
  input  logic [DATA_W-1:0] pushData,
  input  logic [IDX_W-1:0] lookupIdx,
  output logic hit,
  output logic [DATA_W-1:0] hitData,
  output logic drain,
  output logic [IDX_W-1:0] headIdx,
  output logic [DATA_W-1:0] headData,
  output logic [1:0] count
);
  sbEntry_t entries [SB_DEPTH];
  logic head, tail, young, youngHit, oldHit;
  assign tail = head ^ count[0];
  assign young = head ^ count[1];
  assign youngHit = entries[young].valid && entries[young].idx == lookupIdx;
  assign oldHit = entries[head].valid && entries[head].idx == lookupIdx;
  assign hit = youngHit || oldHit;
  assign hitData = youngHit ? entries[young].data : entries[head].data;
  assign headIdx = entries[head].idx;
  assign headData = entries[head].data;
  // a store only touches the array when the buffer is full, freeing the slot it fills
  assign drain = !rst && count != 2'd0 && (push ? count == 2'd2 : !load);
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      if (drain) begin
        entries[head].valid <= 1'b0;
        head <= ~head;
      end
      if (push) entries[tail] <= '{valid: 1'b1, idx: pushIdx, data: pushData};
      count <= count + {1'b0, push} - {1'b0, drain};
    end
  end
endmodule

// File: rtl/mem2_stage.sv
// mem2_stage: second memory stage with buffered stores, forwarded loads and WB registers
module mem2_stage
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic MemWrite2,
  input  logic MemRead2,
  input  logic [31:0] address2,
  input  logic [DATA_W-1:0] memoryWriteData2,
  input  logic RegWriteMEM2,
  input  logic MemtoRegMEM2,
  input  logic [4:0] writeRegMEM2,
  output logic [DATA_W-1:0] memoryReadDataWB,
  output logic [31:0] ALUResultWB,
  output logic RegWriteWB,
  output logic MemtoRegWB,
  output logic [4:0] writeRegWB,
  output logic [1:0] sbCount
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0] idx, headIdx;
  logic [DATA_W-1:0] hitData, headData;
  logic hit, drain, load;
  assign idx = address2[8:1];
  assign load = MemRead2 && !MemWrite2;
  store_buffer sb (
    .clk(clk),
    .rst(rst),
    .push(MemWrite2),
    .load(MemRead2),
    .pushIdx(idx),
    .pushData(memoryWriteData2),
    .lookupIdx(idx),
    .hit(hit),
    .hitData(hitData),
    .drain(drain),
    .headIdx(headIdx),
    .headData(headData),
    .count(sbCount)
  );
  always_ff @(posedge clk) begin
    if (drain) mem[headIdx] <= headData;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      memoryReadDataWB <= '0;
      ALUResultWB <= '0;
      RegWriteWB <= 1'b0;
      MemtoRegWB <= 1'b0;
      writeRegWB <= '0;
    end else begin
      memoryReadDataWB <= load ? (hit ? hitData : mem[idx]) : '0;
      ALUResultWB <= address2;
      RegWriteWB <= RegWriteMEM2;
      MemtoRegWB <= MemtoRegMEM2;
      writeRegWB <= writeRegMEM2;
    end
  end
endmodule
